// File: rtl/mod_determinante_3x3.sv
// mod_determinante_3x3: multi-cycle signed 3x3 determinant with a wrap-around 8-bit result and an overflow flag.
module mod_determinante_3x3 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic [7:0] d,
  input  logic [7:0] e,
  input  logic [7:0] f,
  input  logic [7:0] g,
  input  logic [7:0] h,
  input  logic [7:0] i,
  output logic [7:0] resultado,
  output logic       overflow,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, MINOR, SUM, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] in_w [9];
  logic [7:0] op_q [9];
  logic signed [16:0] x [9];
  logic signed [16:0] m_q [3];
  logic signed [16:0] m_d [3];
  logic signed [25:0] det_q, det_d;
  logic [7:0] resultado_q;
  logic overflow_q, done_q;
  assign in_w = '{a, b, c, d, e, f, g, h, i};
  for (genvar k = 0; k < 9; k++) begin : g_ext
    assign x[k] = 17'($signed(op_q[k]));
  end
  // Minors fit in 17 bits exactly (|value| <= 2*128*128), so 17-bit arithmetic is lossless
  assign m_d[0] = x[4] * x[8] - x[5] * x[7];
  assign m_d[1] = x[3] * x[8] - x[5] * x[6];
  assign m_d[2] = x[3] * x[7] - x[4] * x[6];
  assign det_d = 26'(x[0]) * 26'(m_q[0]) - 26'(x[1]) * 26'(m_q[1]) + 26'(x[2]) * 26'(m_q[2]);
  always_comb begin
    state_d = state_q == IDLE  ? (start ? MINOR : IDLE) :
              state_q == MINOR ? SUM :
              state_q == SUM   ? DONE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '{default: '0};
      m_q         <= '{default: '0};
      det_q       <= '0;
      resultado_q <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= state_q == DONE;
      if (state_q == IDLE && start) op_q <= in_w;
      if (state_q == MINOR) m_q <= m_d;
      if (state_q == SUM) det_q <= det_d;
      if (state_q == DONE) begin
        resultado_q <= det_q[7:0];
        overflow_q  <= det_q != 26'($signed(det_q[7:0]));
      end
    end
  end
  assign resultado = resultado_q;
  assign overflow  = overflow_q;
  assign done      = done_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_mod_determinante_3x3.sv
// tb_mod_determinante_3x3: scoreboard bench for the 3x3 determinant unit.
module tb_mod_determinante_3x3;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] a, b, c, d, e, f, g, h, i;
  logic [7:0] resultado;
  logic overflow, busy, done;
  typedef struct packed {logic [7:0] r; logic o;} exp_t;
  exp_t sb [$];
  int checks = 0, errors = 0, cyc = 0, cap = 0;
  mod_determinante_3x3 dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h), .i(i),
    .resultado(resultado), .overflow(overflow), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [71:0] mat(int p0, int p1, int p2, int p3, int p4, int p5, int p6, int p7, int p8);
    return {8'(p0), 8'(p1), 8'(p2), 8'(p3), 8'(p4), 8'(p5), 8'(p6), 8'(p7), 8'(p8)};
  endfunction
  // Rule of Sarrus on sign-extended bytes
  function automatic int det_of(input logic [71:0] v);
    int m [9];
    for (int k = 0; k < 9; k++) m[k] = int'($signed(v[71-8*k -: 8]));
    return m[0]*m[4]*m[8] + m[1]*m[5]*m[6] + m[2]*m[3]*m[7]
         - m[2]*m[4]*m[6] - m[1]*m[3]*m[8] - m[0]*m[5]*m[7];
  endfunction
  function automatic exp_t expect_of(input logic [71:0] v);
    int dt;
    exp_t x;
    dt = det_of(v);
    x.r = dt[7:0];
    x.o = dt > 127 || dt < -128;
    return x;
  endfunction
  task automatic set_in(input logic [71:0] v);
    {a, b, c, d, e, f, g, h, i} = v;
  endtask
  task automatic issue(input logic [71:0] v);
    @(posedge clk); #1;
    set_in(v);
    start = 1'b1;
    sb.push_back(expect_of(v));
    @(posedge clk); #1;
    cap = cyc;
    start = 1'b0;
  endtask
  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    start = 1'b1;
    set_in(mat(5, 6, 7, 1, 2, 3, 9, 8, 4));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks += 4;
    if (resultado !== 8'h00) begin errors++; $display("FAIL reset_resultado got %h want 00", resultado); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
  endtask
  task automatic test_vectors;
    logic [71:0] tbl [$];
    logic [95:0] rnd;
    exp_t x;
    bit got;
    tbl = '{mat(1,1,1,1,1,1,1,1,1), mat(1,1,1,2,1,2,1,1,2), mat(-1,-4,-7,-2,-3,-8,-1,-2,-7),
            mat(0,1,2,3,1,2,3,0,0), mat(3,3,3,3,3,3,3,3,3), mat(10,0,0,0,10,0,0,0,10),
            mat(-128,0,0,0,-128,0,0,0,-128), mat(127,-128,-128,-128,127,-128,-128,-128,127),
            mat(-128,-128,-128,-128,-128,-128,-128,-128,-128), mat(2,0,0,0,3,0,0,0,-5),
            mat(-128,0,0,0,1,0,0,0,1), mat(127,0,0,0,1,0,0,0,1), mat(2,0,0,0,64,0,0,0,1),
            mat(0,-128,0,0,0,-128,-128,0,0)};
    for (int k = 0; k < 16; k++) begin
      rnd = {$urandom(), $urandom(), $urandom()};
      tbl.push_back(rnd[71:0]);
    end
    foreach (tbl[n]) begin
      issue(tbl[n]);
      wait_done(got);
      checks += 5;
      if (!got) begin
        errors++;
        $display("FAIL vec%0d_done no done pulse within budget", n);
        void'(sb.pop_front());
        continue;
      end
      x = sb.pop_front();
      if (cyc - cap !== 3) begin errors++; $display("FAIL vec%0d_latency got %0d want 3", n, cyc - cap); end
      if (busy !== 1'b0) begin errors++; $display("FAIL vec%0d_busy got %b want 0", n, busy); end
      if (resultado !== x.r) begin errors++; $display("FAIL vec%0d_resultado got %h want %h", n, resultado, x.r); end
      if (overflow !== x.o) begin errors++; $display("FAIL vec%0d_overflow got %b want %b", n, overflow, x.o); end
      @(negedge clk);
      if (done !== 1'b0 || resultado !== x.r) begin
        errors++;
        $display("FAIL vec%0d_hold done %b res %h want done 0 res %h", n, done, resultado, x.r);
      end
    end
  endtask
  task automatic test_isolation;
    exp_t x;
    bit got;
    issue(mat(10, 0, 0, 0, 10, 0, 0, 0, 10));
    set_in(mat(127, 127, 127, 127, -128, 127, 127, 127, 127));
    @(negedge clk);
    set_in(mat(-1, 5, 9, 2, 2, 2, 7, -7, 3));
    wait_done(got);
    x = sb.pop_front();
    checks += 2;
    if (!got) begin errors++; $display("FAIL isolation_done no done pulse within budget"); end
    if (resultado !== 8'hE8 || overflow !== 1'b1 || x.r !== 8'hE8) begin
      errors++;
      $display("FAIL isolation_result got %h/%b want e8/1", resultado, overflow);
    end
  endtask
  task automatic test_reset_mid;
    int pulses;
    for (int p = 0; p < 2; p++) begin
      issue(mat(1, 2, 3, 4, 5, 6, 7, 8, 10));
      void'(sb.pop_front());
      if (p == 1) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (done) pulses++;
      end
      checks += 2;
      if (pulses !== 0) begin errors++; $display("FAIL reset_mid%0d_done got %0d pulses want 0", p, pulses); end
      if (resultado !== 8'h00 || overflow !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid%0d_outputs got %h/%b/%b want 00/0/0", p, resultado, overflow, busy);
      end
    end
  endtask
  task automatic test_back_to_back;
    logic [71:0] v2;
    exp_t x;
    bit got;
    int d1;
    v2 = mat(-3, 7, 2, 5, -9, 4, 1, 6, -8);
    issue(mat(1, 1, 1, 2, 1, 2, 1, 1, 2));
    wait_done(got);
    d1 = cyc;
    x = sb.pop_front();
    checks += 2;
    if (!got || resultado !== x.r) begin errors++; $display("FAIL b2b_first got %h want %h", resultado, x.r); end
    set_in(v2);
    start = 1'b1;
    sb.push_back(expect_of(v2));
    @(posedge clk); #1 start = 1'b0;
    wait_done(got);
    x = sb.pop_front();
    if (!got || cyc - d1 !== 4 || resultado !== x.r || overflow !== x.o) begin
      errors++;
      $display("FAIL b2b_second got %h/%b gap %0d want %h/%b gap 4", resultado, overflow, cyc - d1, x.r, x.o);
    end
  endtask
  task automatic test_hold_start;
    exp_t x;
    bit got;
    int pulses;
    @(posedge clk); #1;
    set_in(mat(2, -1, 0, 4, 3, 5, -6, 1, 7));
    start = 1'b1;
    sb.push_back(expect_of(mat(2, -1, 0, 4, 3, 5, -6, 1, 7)));
    @(posedge clk); #1;
    set_in(mat(9, 9, 1, 2, 3, 4, 5, 6, 8));
    @(negedge clk);
    checks += 3;
    if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy got %b want 1", busy); end
    wait_done(got);
    start = 1'b0;
    x = sb.pop_front();
    if (!got || resultado !== x.r || overflow !== x.o) begin
      errors++;
      $display("FAIL hold_result got %h/%b want %h/%b", resultado, overflow, x.r, x.o);
    end
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    if (pulses !== 0) begin errors++; $display("FAIL hold_extra got %0d pulses want 0", pulses); end
  endtask
  initial begin
    test_reset();
    test_vectors();
    test_isolation();
    test_reset_mid();
    test_back_to_back();
    test_hold_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
